// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer with a
// one-entry output buffer towards decode; supports stall and redirect/flush.
module pc_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               pc_redirect,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               req;

  // A request is only issued when the buffer is empty or draining this cycle,
  // so the buffer is guaranteed empty whenever a response lands in S_WAIT.
  assign req = (state_q == S_REQ) && !rst && !pc_redirect && (!valid_q || !stall);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    if (pc_redirect) begin
      pc_d    = pc_next;
      valid_d = 1'b0;
      if (state_q != S_REQ) begin
        state_d = imem_rvalid ? S_REQ : S_DROP;
      end
    end else begin
      if (valid_q && !stall) begin
        valid_d = 1'b0;
      end
      case (state_q)
        S_REQ: begin
          if (req && imem_gnt) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + PC_W'(PC_STEP);
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule
